stream_rr_arbiter: RTL

STREAM_RR_ARBITER -- requirements
Module: stream_rr_arbiter

---
 rtl/stream_rr_arbiter.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/stream_rr_arbiter.sv
// Four-input round-robin packet arbiter. Locks onto one requester for a whole
// packet and forwards its beats through a single-entry output register.
module stream_rr_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush_i,
  input  logic [3:0]              req_valid_i,
  output logic [3:0]              req_ready_o,
  input  logic [4*DATA_WIDTH-1:0] req_data_i,
  input  logic [3:0]              req_last_i,
  output logic                    valid_out,
  input  logic                    ready_out,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    last_out,
  output logic [1:0]              grant_id_out,
  output logic                    busy_o
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [1:0]            ptr_q, ptr_d;
  logic [1:0]            gnt_q, gnt_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  last_q, last_d;
  logic [1:0]            id_q, id_d;

  logic [DATA_WIDTH-1:0] req_data_arr [4];
  logic [3:0]            ready_vec;
  logic                  can_load;
  logic                  xfer;
  logic                  timeout_hit;

  // First valid requester at or after the pointer, wrapping modulo 4.
  function automatic logic [1:0] rr_pick(input logic [3:0] v, input logic [1:0] p);
    logic [1:0] idx;
    logic [1:0] sel;
    logic       found;
    sel   = p;
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      idx = p + 2'(i);
      if (!found && v[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      req_data_arr[k] = req_data_i[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gnt_d     = gnt_q;
    cnt_d     = cnt_q;
    valid_d   = valid_q;
    data_d    = data_q;
    last_d    = last_q;
    id_d      = id_q;
    ready_vec = 4'b0000;
    xfer      = 1'b0;
    can_load  = (!valid_q || ready_out) && !flush_i;

    if (valid_q && ready_out) begin
      valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if ((|req_valid_i) && !flush_i) begin
          gnt_d   = rr_pick(req_valid_i, ptr_q);
          state_d = ST_LOCKED;
          cnt_d   = '0;
        end
      end
      ST_LOCKED: begin
        ready_vec[gnt_q] = can_load;
        xfer             = req_valid_i[gnt_q] && can_load;
        if (xfer) begin
          valid_d = 1'b1;
          data_d  = req_data_arr[gnt_q];
          last_d  = req_last_i[gnt_q];
          id_d    = gnt_q;
          cnt_d   = '0;
          if (req_last_i[gnt_q]) begin
            state_d = ST_IDLE;
            ptr_d   = gnt_q + 2'd1;
          end
        end else if (TIMEOUT != 0) begin
          // Stalled requester: give up the lock but keep any buffered beat.
          if (timeout_hit) begin
            state_d = ST_IDLE;
            ptr_d   = gnt_q + 2'd1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (flush_i) begin
      state_d = ST_IDLE;
      valid_d = 1'b0;
      cnt_d   = '0;
      ptr_d   = ptr_q;
      gnt_d   = gnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= 2'd0;
      gnt_q   <= 2'd0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
      id_q    <= 2'd0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
      id_q    <= id_d;
    end
  end

  // Nothing is accepted upstream while reset is applied; the beat would be lost.
  assign req_ready_o  = rst ? 4'b0000 : ready_vec;
  assign valid_out    = valid_q;
  assign data_out     = data_q;
  assign last_out     = last_q;
  assign grant_id_out = id_q;
  assign busy_o       = (state_q == ST_LOCKED);

endmodule
